fpu_cmd_sequencer: RTL and testbench

FPU_CMD_SEQUENCER -- requirements
Module: fpu_cmd_sequencer

---
 rtl/fpu_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fpu_cmd_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmd_sequencer.sv
// Sequences one FPU operation per accepted command over the CSR strobe bus and
// holds the captured result and flags until the downstream side takes them.
module fpu_cmd_sequencer #(
    parameter int unsigned RESULT_WAIT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [3:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    output logic        busy,
    output logic [15:0] op_count,
    output logic        ChipSelect,
    output logic        Write,
    output logic        Read,
    output logic [1:0]  Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_WAIT, S_RD_RES, S_RD_FLG, S_CAP_FLG, S_DONE
    } state_e;

    localparam logic [7:0] WAIT_LOAD = 8'(RESULT_WAIT);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;
    logic [15:0] op_count_q, op_count_d;
    logic        cs_q, cs_d, write_q, write_d, read_q, read_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        flags_d    = flags_q;
        op_count_d = op_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    state_d = S_WR_A;
                end
            end
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_WR_OP;
            S_WR_OP: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd1) state_d = S_RD_RES;
                else                    wait_cnt_d = wait_cnt_q - 8'd1;
            end
            S_RD_RES: state_d = S_RD_FLG;
            // Read data lags the Read strobe by one cycle, so each capture sits one state later.
            S_RD_FLG: begin
                result_d = ReadData;
                state_d  = S_CAP_FLG;
            end
            S_CAP_FLG: begin
                flags_d = ReadData[2:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus strobes are decoded from the next state so they appear registered alongside it.
        write_d = 1'b0;
        read_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_d)
            S_WR_A:   begin write_d = 1'b1; addr_d = 2'd0; wdata_d = a_d; end
            S_WR_B:   begin write_d = 1'b1; addr_d = 2'd1; wdata_d = b_d; end
            S_WR_OP:  begin write_d = 1'b1; addr_d = 2'd2; wdata_d = {28'd0, op_d}; end
            S_RD_RES: begin read_d  = 1'b1; addr_d = 2'd3; end
            S_RD_FLG: begin read_d  = 1'b1; addr_d = 2'd2; end
            default:  ;
        endcase
        cs_d        = write_d | read_d;
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            wait_cnt_q  <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            op_count_q  <= '0;
            cs_q        <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            wait_cnt_q  <= wait_cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            op_count_q  <= op_count_d;
            cs_q        <= cs_d;
            write_q     <= write_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign op_count   = op_count_q;
    assign ChipSelect = cs_q;
    assign Write      = write_q;
    assign Read       = read_q;
    assign Address    = addr_q;
    assign WriteData  = wdata_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Testbench for fpu_cmd_sequencer: CSR bus responder, write/response scoreboards,
// and per-scenario tasks on a RESULT_WAIT=4 and a RESULT_WAIT=1 instance.
module tb_fpu_cmd_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst = 1'b1;
    logic        cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_op = '0;
    logic        cmd_ready, rsp_valid, busy, ChipSelect, Write, Read;
    logic [31:0] rsp_result, WriteData, ReadData;
    logic [2:0]  rsp_flags;
    logic [15:0] op_count;
    logic [1:0]  Address;

    logic        s_cmd_valid = 1'b0, s_rsp_ready = 1'b0;
    logic [31:0] s_cmd_a = '0, s_cmd_b = '0;
    logic [3:0]  s_cmd_op = '0;
    logic        s_cmd_ready, s_rsp_valid, s_busy, s_cs, s_write, s_read;
    logic [31:0] s_rsp_result, s_wdata, s_rdata;
    logic [2:0]  s_rsp_flags;
    logic [15:0] s_op_count;
    logic [1:0]  s_addr;

    fpu_cmd_sequencer #(.RESULT_WAIT(4)) dut (
        .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy), .op_count(op_count), .ChipSelect(ChipSelect), .Write(Write),
        .Read(Read), .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    fpu_cmd_sequencer #(.RESULT_WAIT(1)) dut_short (
        .Clk(Clk), .Rst(Rst), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_a(s_cmd_a), .cmd_b(s_cmd_b), .cmd_op(s_cmd_op), .rsp_valid(s_rsp_valid),
        .rsp_ready(s_rsp_ready), .rsp_result(s_rsp_result), .rsp_flags(s_rsp_flags),
        .busy(s_busy), .op_count(s_op_count), .ChipSelect(s_cs), .Write(s_write),
        .Read(s_read), .Address(s_addr), .WriteData(s_wdata), .ReadData(s_rdata)
    );

    typedef struct packed { logic [1:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [31:0] result; logic [2:0] flags; } rsp_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    wr_t  mon_w;
    rsp_t mon_r;

    int          checks = 0, failures = 0, cyc = 0;
    logic [31:0] bm_result = 32'h0;
    logic [2:0]  bm_flags = 3'b0;
    logic [15:0] exp_count = '0;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD5;
    localparam logic [31:0] S_RES = 32'hC0A0_0000;
    localparam logic [2:0]  S_FLG = 3'b100;

    always @(posedge Clk) cyc <= cyc + 1;

    // CSR responders: read data appears the cycle after Read, junk otherwise.
    always @(posedge Clk)
        ReadData <= Read ? ((Address == 2'd3) ? bm_result : {29'd0, bm_flags}) : JUNK;
    always @(posedge Clk)
        s_rdata <= s_read ? ((s_addr == 2'd3) ? S_RES : {29'd0, S_FLG}) : JUNK;

    // Bus protocol monitor and scoreboard consumer for the RESULT_WAIT=4 instance.
    always @(negedge Clk) begin
        #1;
        if (Rst === 1'b0) begin
            checks++;
            if (ChipSelect !== (Write | Read) || (Write && Read)) begin
                failures++;
                $display("FAIL strobes @%0d: cs=%b wr=%b rd=%b, need cs==wr|rd and not both",
                         cyc, ChipSelect, Write, Read);
            end
            if (Write === 1'b1) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write @%0d: addr=%0d data=%h, none expected",
                             cyc, Address, WriteData);
                end else begin
                    mon_w = wr_q.pop_front();
                    if (Address !== mon_w.addr || WriteData !== mon_w.data) begin
                        failures++;
                        $display("FAIL bus_write @%0d: addr=%0d data=%h, need addr=%0d data=%h",
                                 cyc, Address, WriteData, mon_w.addr, mon_w.data);
                    end
                end
            end
            if (rsp_valid === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_rsp @%0d: rsp_valid=1 with no command outstanding", cyc);
                end else if (rsp_ready === 1'b1) begin
                    mon_r = rsp_q.pop_front();
                    checks++;
                    if (rsp_result !== mon_r.result || rsp_flags !== mon_r.flags) begin
                        failures++;
                        $display("FAIL rsp_data @%0d: result=%h flags=%b, need result=%h flags=%b",
                                 cyc, rsp_result, rsp_flags, mon_r.result, mon_r.flags);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic reset_dut();
        Rst = 1'b1;
        cmd_valid = 1'b0;
        s_cmd_valid = 1'b0;
        wr_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        exp_count = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_idle: cmd_ready=%b after %0d cycles, need 1", cmd_ready, n);
        end
    endtask

    task automatic push_expect(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                               input logic [31:0] res, input logic [2:0] fl);
        wr_q.push_back(wr_t'{addr: 2'd0, data: a});
        wr_q.push_back(wr_t'{addr: 2'd1, data: b});
        wr_q.push_back(wr_t'{addr: 2'd2, data: {28'd0, op}});
        rsp_q.push_back(rsp_t'{result: res, flags: fl});
    endtask

    // One command with a per-cycle trace check; hold = cycles rsp_ready stays low in DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] res, input logic [2:0] fl, input int hold,
                          input string tag);
        logic       ew, er;
        logic [1:0] ea;
        wait_idle();
        bm_result = res;
        bm_flags  = fl;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        push_expect(a, b, op, res, fl);
        for (int k = 1; k <= 11; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
            end
            ew = (k >= 1 && k <= 3);
            er = (k == 8 || k == 9);
            ea = (k == 1) ? 2'd0 : (k == 2) ? 2'd1 : (k == 8) ? 2'd3 : 2'd2;
            checks++;
            if ({Write, Read} !== {ew, er} || ((ew || er) && Address !== ea)) begin
                failures++;
                $display("FAIL %s seq T+%0d: wr=%b rd=%b addr=%0d, need wr=%b rd=%b addr=%0d",
                         tag, k, Write, Read, Address, ew, er, ea);
            end
            checks++;
            if ({busy, cmd_ready, rsp_valid} !== {1'b1, 1'b0, (k == 11)}) begin
                failures++;
                $display("FAIL %s status T+%0d: busy=%b ready=%b rsp_valid=%b, need 1 0 %b",
                         tag, k, busy, cmd_ready, rsp_valid, (k == 11));
            end
        end
        checks++;
        if (rsp_result !== res || rsp_flags !== fl) begin
            failures++;
            $display("FAIL %s result: %h/%b, need %h/%b", tag, rsp_result, rsp_flags, res, fl);
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge Clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== res || rsp_flags !== fl || op_count !== exp_count) begin
                failures++;
                $display("FAIL %s hold %0d: valid=%b result=%h flags=%b count=%h, need 1 %h %b %h",
                         tag, h, rsp_valid, rsp_result, rsp_flags, op_count, res, fl, exp_count);
            end
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        exp_count = sat_inc(exp_count);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== exp_count) begin
            failures++;
            $display("FAIL %s complete: valid=%b ready=%b count=%h, need 0 1 %h",
                     tag, rsp_valid, cmd_ready, op_count, exp_count);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({cmd_ready, busy, rsp_valid, ChipSelect, Write, Read} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b cs=%b wr=%b rd=%b, need 1 0 0 0 0 0",
                     cmd_ready, busy, rsp_valid, ChipSelect, Write, Read);
        end
        checks++;
        if (Address !== 2'd0 || WriteData !== 32'd0 || rsp_result !== 32'd0 ||
            rsp_flags !== 3'd0 || op_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_data: addr=%0d wdata=%h result=%h flags=%b count=%h, need all 0",
                     Address, WriteData, rsp_result, rsp_flags, op_count);
        end
        checks++;
        if ({s_cmd_ready, s_busy, s_rsp_valid, s_op_count} !== {3'b100, 16'd0}) begin
            failures++;
            $display("FAIL reset_short: ready=%b busy=%b valid=%b count=%h, need 1 0 0 0",
                     s_cmd_ready, s_busy, s_rsp_valid, s_op_count);
        end
    endtask

    task automatic test_single();
        run_op(32'h3F80_0000, 32'h4000_0000, 4'h0, 32'h4040_0000, 3'b000, 0, "single");
    endtask

    task automatic test_hold();
        run_op(32'hC120_0000, 32'h3E80_0000, 4'h3, 32'h7F80_0000, 3'b010, 5, "hold");
    endtask

    task automatic test_back_to_back();
        int acc[$];
        wait_idle();
        rsp_ready = 1'b1;
        bm_result = 32'h4120_0000;
        bm_flags  = 3'b001;
        cmd_valid = 1'b1;
        for (int c = 0; c < 80 && acc.size() < 4; c++) begin
            cmd_a  = 32'h1000_0000 + 32'(acc.size());
            cmd_b  = 32'h2000_0000 - 32'(acc.size());
            cmd_op = 4'(acc.size() + 5);
            if (cmd_ready === 1'b1) begin
                acc.push_back(cyc);
                push_expect(cmd_a, cmd_b, cmd_op, bm_result, bm_flags);
            end
            @(negedge Clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (acc.size() != 4) begin
            failures++;
            $display("FAIL b2b_accepts: got %0d accepts, need 4", acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 12) begin
                failures++;
                $display("FAIL b2b_spacing %0d: %0d cycles, need 12", i, acc[i] - acc[i-1]);
            end
        end
        for (int n = 0; n < 40 && rsp_q.size() > 0; n++) @(negedge Clk);
        for (int i = 0; i < acc.size(); i++) exp_count = sat_inc(exp_count);
        checks++;
        if (rsp_q.size() != 0 || op_count !== exp_count) begin
            failures++;
            $display("FAIL b2b_drain: pending=%0d count=%h, need 0 %h", rsp_q.size(), op_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        reset_dut();
        wait_idle();
        rsp_ready = 1'b1;
        bm_result = 32'h1234_5678;
        bm_flags  = 3'b111;
        cmd_a = 32'hAAAA_0001; cmd_b = 32'h5555_0002; cmd_op = 4'h9; cmd_valid = 1'b1;
        push_expect(cmd_a, cmd_b, cmd_op, bm_result, bm_flags);
        @(negedge Clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge Clk);
        checks++;
        if (wr_q.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_writes: %0d writes outstanding at T+6, need 0", wr_q.size());
        end
        Rst = 1'b1;
        wr_q.delete();
        rsp_q.delete();
        @(negedge Clk);
        checks++;
        if ({ChipSelect, Write, Read, cmd_ready, busy, rsp_valid} !== 6'b000100 ||
            op_count !== 16'd0 || Address !== 2'd0 || WriteData !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid T+7: cs=%b wr=%b rd=%b ready=%b busy=%b valid=%b count=%h, need 0 0 0 1 0 0 0",
                     ChipSelect, Write, Read, cmd_ready, busy, rsp_valid, op_count);
        end
        Rst = 1'b0;
        repeat (15) begin
            @(negedge Clk);
            if (rsp_valid !== 1'b0 || Write !== 1'b0 || Read !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || op_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid_drop: activity=%b count=%h, need 0 0", seen, op_count);
        end
    endtask

    task automatic test_saturation();
        wait_idle();
        force dut.op_count_q = 16'hFFFE;
        @(negedge Clk);
        release dut.op_count_q;
        exp_count = 16'hFFFE;
        @(negedge Clk);
        checks++;
        if (op_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload: count=%h, need fffe", op_count);
        end
        run_op(32'h0000_0001, 32'h8000_0001, 4'hF, 32'h0080_0000, 3'b100, 0, "sat_to_max");
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 4'h1, 32'h7F80_0000, 3'b011, 0, "sat_hold");
    endtask

    task automatic test_short_wait();
        logic       ew, er;
        logic [1:0] ea;
        logic [31:0] ed;
        s_rsp_ready = 1'b1;
        s_cmd_a = 32'h4248_0000; s_cmd_b = 32'hC2C8_0000; s_cmd_op = 4'h6; s_cmd_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                s_cmd_valid = 1'b0;
                s_cmd_a = '0; s_cmd_b = '0; s_cmd_op = '0;
            end
            ew = (k >= 1 && k <= 3);
            er = (k == 5 || k == 6);
            ea = (k == 1) ? 2'd0 : (k == 2) ? 2'd1 : (k == 5) ? 2'd3 : 2'd2;
            ed = (k == 1) ? 32'h4248_0000 : (k == 2) ? 32'hC2C8_0000 : 32'h0000_0006;
            checks++;
            if ({s_write, s_read, s_cs} !== {ew, er, ew | er} || ((ew || er) && s_addr !== ea) ||
                (ew && s_wdata !== ed)) begin
                failures++;
                $display("FAIL short seq T+%0d: wr=%b rd=%b cs=%b addr=%0d data=%h, need wr=%b rd=%b addr=%0d data=%h",
                         k, s_write, s_read, s_cs, s_addr, s_wdata, ew, er, ea, ed);
            end
            checks++;
            if (s_rsp_valid !== (k == 8)) begin
                failures++;
                $display("FAIL short rsp_valid T+%0d: %b, need %b", k, s_rsp_valid, (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (s_rsp_result !== S_RES || s_rsp_flags !== S_FLG) begin
                    failures++;
                    $display("FAIL short result: %h/%b, need %h/%b", s_rsp_result, s_rsp_flags, S_RES, S_FLG);
                end
            end
        end
        checks++;
        if (s_cmd_ready !== 1'b1 || s_op_count !== 16'd1) begin
            failures++;
            $display("FAIL short complete: ready=%b count=%h, need 1 0001", s_cmd_ready, s_op_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded its time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short_wait();
        test_single();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        repeat (3) @(negedge Clk);
        checks++;
        if (wr_q.size() != 0 || rsp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: writes=%0d responses=%0d left, need 0 0", wr_q.size(), rsp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
